// File: rtl/fma_vector_checker.sv
// Test-vector engine for fused multiply-add units: issues operands to the unit under test,
// queues expected results for in-order responses and keeps pass/fail statistics.
module fma_vector_checker #(
    parameter int EXP_WIDTH = 11,
    parameter int SIG_WIDTH = 53,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           vec_valid,
    output logic                           vec_ready,
    input  logic [1:0]                     vec_op,
    input  logic [1:0]                     vec_rm,
    input  logic [EXP_WIDTH+SIG_WIDTH-1:0] vec_a,
    input  logic [EXP_WIDTH+SIG_WIDTH-1:0] vec_b,
    input  logic [EXP_WIDTH+SIG_WIDTH-1:0] vec_c,
    input  logic [EXP_WIDTH+SIG_WIDTH-1:0] vec_z_exp,
    input  logic [4:0]                     vec_flags_exp,
    output logic                           dut_req_valid,
    output logic [1:0]                     dut_req_op,
    output logic [1:0]                     dut_req_rm,
    output logic [EXP_WIDTH+SIG_WIDTH-1:0] dut_req_a,
    output logic [EXP_WIDTH+SIG_WIDTH-1:0] dut_req_b,
    output logic [EXP_WIDTH+SIG_WIDTH-1:0] dut_req_c,
    input  logic                           dut_resp_valid,
    input  logic [EXP_WIDTH+SIG_WIDTH-1:0] dut_resp_z,
    input  logic [4:0]                     dut_resp_flags,
    input  logic                           cmp_nan_any,
    input  logic [4:0]                     flags_mask,
    output logic [CNT_WIDTH-1:0]           pass_count,
    output logic [CNT_WIDTH-1:0]           fail_count,
    output logic                           first_fail_valid,
    output logic [CNT_WIDTH-1:0]           first_fail_index,
    output logic [EXP_WIDTH+SIG_WIDTH-1:0] first_fail_z,
    output logic [4:0]                     first_fail_flags,
    output logic                           underflow_err,
    output logic                           idle
);
    localparam int FLEN  = EXP_WIDTH + SIG_WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [FLEN-1:0]      z_mem     [DEPTH];
    logic [4:0]           flags_mem [DEPTH];
    logic [CNT_WIDTH-1:0] index_mem [DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     count;
    logic [CNT_WIDTH-1:0] next_index;

    logic                 push;
    logic                 pop;
    logic                 zmatch;
    logic                 match;
    logic [FLEN-1:0]      head_z;
    logic [4:0]           head_flags;
    logic [CNT_WIDTH-1:0] head_index;

    // Exponent all ones with a nonzero fraction; infinities are excluded.
    function automatic logic is_nan(input logic [FLEN-1:0] v);
        return (&v[FLEN-2 -: EXP_WIDTH]) && (|v[SIG_WIDTH-2:0]);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign vec_ready = (count < OCC_W'(DEPTH));
    assign push      = vec_valid && vec_ready;
    assign pop       = dut_resp_valid && (count != '0);
    assign idle      = (count == '0) && !dut_req_valid;

    assign head_z     = z_mem[rd_ptr];
    assign head_flags = flags_mem[rd_ptr];
    assign head_index = index_mem[rd_ptr];

    assign zmatch = (dut_resp_z == head_z) ||
                    (cmp_nan_any && is_nan(dut_resp_z) && is_nan(head_z));
    assign match  = zmatch && (((dut_resp_flags ^ head_flags) & flags_mask) == 5'b0);

    always_ff @(posedge clock) begin
        if (push) begin
            z_mem[wr_ptr]     <= vec_z_exp;
            flags_mem[wr_ptr] <= vec_flags_exp;
            index_mem[wr_ptr] <= next_index;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            next_index       <= '0;
            dut_req_valid    <= 1'b0;
            dut_req_op       <= '0;
            dut_req_rm       <= '0;
            dut_req_a        <= '0;
            dut_req_b        <= '0;
            dut_req_c        <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_index <= '0;
            first_fail_z     <= '0;
            first_fail_flags <= '0;
            underflow_err    <= 1'b0;
        end else begin
            dut_req_valid <= push;
            if (push) begin
                dut_req_op <= vec_op;
                dut_req_rm <= vec_rm;
                dut_req_a  <= vec_a;
                dut_req_b  <= vec_b;
                dut_req_c  <= vec_c;
                wr_ptr     <= wr_ptr + PTR_W'(1);
                next_index <= next_index + CNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (match) begin
                    pass_count <= sat_inc(pass_count);
                end else begin
                    fail_count <= sat_inc(fail_count);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_index <= head_index;
                        first_fail_z     <= dut_resp_z;
                        first_fail_flags <= dut_resp_flags;
                    end
                end
            end
            if (dut_resp_valid && (count == '0)) begin
                underflow_err <= 1'b1;
            end
            // A push and a pop in the same cycle leave the occupancy unchanged.
            if (push && !pop) begin
                count <= count + OCC_W'(1);
            end else if (pop && !push) begin
                count <= count - OCC_W'(1);
            end
        end
    end
endmodule
